pci_target_burst: RTL and testbench

Parametrised successor to the single-function PCI slave. It is a PCI memory target with an internal word-addressed buffer and a configurable base address, depth and wait states. It supports memory read and write bursts with per-byte enables, and issues target disconnect (Stop) on burst overrun. It sits on the shared AD/CBE bus alongside the testbench master and replaces the separate decoder/devsel/trdy/storage pieces with one sequential block.

---
 rtl/pci_target_burst.sv | 236 +++++++++++++++++++++++
 tb/tb_pci_target_burst.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/pci_target_burst.sv
// ---------------------------------------------------------------------------
// PciTargetBurst -- PCI memory target with an internal word buffer.
//
// Decodes memory read (CBE=0110) and memory write (CBE=0111) bursts that
// fall inside [BASE_ADDR, BASE_ADDR+DEPTH). Each data phase can be stretched
// by WAIT_STATES cycles. Writes honour the active-low byte enables. A burst
// that runs past the end of the buffer is answered with a target disconnect
// (Stop) until the master ends the transaction.
//
// Ports
//   Clock   in   bus clock, everything changes on its rising edge
//   RST     in   synchronous active-high reset
//   Frame   in   active-low, master transaction in progress
//   Irdy    in   active-low initiator ready
//   CBE     in   command (address phase) / active-low byte enables (data)
//   AD_in   in   sampled AD bus
//   AD_out  out  read data for the AD bus
//   AD_oe   out  active-high tristate enable for AD_out
//   Devsel  out  active-low device select
//   Trdy    out  active-low target ready
//   Stop    out  active-low target disconnect
//   Par     out  even parity of the previous read data cycle
//                (only when PCI_PARITY_EN is defined)
//
// Optional feature macro: PCI_PARITY_EN
// ---------------------------------------------------------------------------
module pci_target_burst #(
    parameter logic [31:0] BASE_ADDR   = 32'd21,
    parameter int          DEPTH       = 8,
    parameter int          WAIT_STATES = 0
) (
    input  logic        Clock,
    input  logic        RST,
    input  logic        Frame,
    input  logic        Irdy,
    input  logic [3:0]  CBE,
    input  logic [31:0] AD_in,
    output logic [31:0] AD_out,
    output logic        AD_oe,
    output logic        Devsel,
    output logic        Trdy,
    output logic        Stop
`ifdef PCI_PARITY_EN
    ,
    output logic        Par
`endif
);

    // One extra index bit so that "one past the last word" is representable
    // and the overrun can be detected instead of silently wrapping.
    localparam int AW = $clog2(DEPTH);
    localparam int IW = AW + 1;

    localparam logic [3:0]    CMD_MEM_READ  = 4'b0110;
    localparam logic [3:0]    CMD_MEM_WRITE = 4'b0111;
    localparam logic [2:0]    WS_LOAD       = 3'(WAIT_STATES);
    localparam logic [IW-1:0] DEPTH_IDX     = IW'(DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        BUSWAIT,
        DISC,
        TURN
    } state_t;

    state_t        state_q;
    logic          isRead_q;
    logic [IW-1:0] idx_q;
    logic [2:0]    waitCnt_q;
    logic [31:0]   adOut_q;
    logic          adOe_q;
    logic          devsel_q;
    logic          trdy_q;
    logic          stop_q;
    logic [31:0]   mem_q [DEPTH];

    logic [31:0]   addrOffset;
    logic          addrHit;
    logic          cmdRead;
    logic          cmdWrite;
    logic [IW-1:0] idxInc;
    logic [AW-1:0] addrSlot;
    logic [AW-1:0] idxSlot;
    logic [AW-1:0] incSlot;

    // The lower bound is checked separately so that addresses below the base
    // (which wrap to huge offsets) can never alias into the buffer.
    assign addrOffset = AD_in - BASE_ADDR;
    assign addrHit    = (AD_in >= BASE_ADDR) && (addrOffset < 32'(DEPTH));
    assign cmdRead    = (CBE == CMD_MEM_READ);
    assign cmdWrite   = (CBE == CMD_MEM_WRITE);
    assign idxInc     = idx_q + IW'(1);
    assign addrSlot   = addrOffset[AW-1:0];
    assign idxSlot    = idx_q[AW-1:0];
    assign incSlot    = idxInc[AW-1:0];

    // Bus protocol state machine and buffer. All bus outputs are registered.
    // The buffer is deliberately left out of the reset branch so that data
    // survives a reset.
    always_ff @(posedge Clock) begin
        if (RST) begin
            state_q   <= IDLE;
            isRead_q  <= 1'b0;
            idx_q     <= '0;
            waitCnt_q <= '0;
            adOut_q   <= '0;
            adOe_q    <= 1'b0;
            devsel_q  <= 1'b1;
            trdy_q    <= 1'b1;
            stop_q    <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!Frame) begin
                        idx_q    <= addrOffset[IW-1:0];
                        isRead_q <= cmdRead;
                        if (addrHit && (cmdRead || cmdWrite)) begin
                            state_q  <= DATA;
                            devsel_q <= 1'b0;
                            adOe_q   <= cmdRead;
                            // With no wait states the first data phase is
                            // ready straight away, so fetch from the
                            // freshly decoded address.
                            if (WAIT_STATES == 0) begin
                                trdy_q <= 1'b0;
                                if (cmdRead) begin
                                    adOut_q <= mem_q[addrSlot];
                                end
                            end else begin
                                trdy_q    <= 1'b1;
                                waitCnt_q <= WS_LOAD;
                            end
                        end else begin
                            state_q <= BUSWAIT;
                        end
                    end
                end

                DATA: begin
                    if (trdy_q) begin
                        // Counting down the wait states of this data phase.
                        if (waitCnt_q <= 3'd1) begin
                            trdy_q    <= 1'b0;
                            waitCnt_q <= '0;
                            if (isRead_q) begin
                                adOut_q <= mem_q[idxSlot];
                            end
                        end else begin
                            waitCnt_q <= waitCnt_q - 3'd1;
                        end
                    end else if (!Irdy) begin
                        if (!isRead_q) begin
                            for (int b = 0; b < 4; b++) begin
                                if (!CBE[b]) begin
                                    mem_q[idxSlot][8*b +: 8] <= AD_in[8*b +: 8];
                                end
                            end
                        end
                        idx_q <= idxInc;
                        // A final transfer takes priority over the overrun
                        // check: a burst that exactly fills the buffer ends
                        // normally.
                        if (Frame) begin
                            state_q  <= TURN;
                            devsel_q <= 1'b1;
                            trdy_q   <= 1'b1;
                            adOe_q   <= 1'b0;
                        end else if (idxInc == DEPTH_IDX) begin
                            state_q <= DISC;
                            stop_q  <= 1'b0;
                            trdy_q  <= 1'b1;
                            adOe_q  <= 1'b0;
                        end else if (WAIT_STATES == 0) begin
                            if (isRead_q) begin
                                adOut_q <= mem_q[incSlot];
                            end
                        end else begin
                            trdy_q    <= 1'b1;
                            waitCnt_q <= WS_LOAD;
                        end
                    end
                end

                // Keep Devsel asserted while disconnecting so the master
                // sees a target disconnect rather than a master abort.
                DISC: begin
                    if (Frame) begin
                        state_q  <= TURN;
                        stop_q   <= 1'b1;
                        devsel_q <= 1'b1;
                    end
                end

                TURN: begin
                    state_q <= IDLE;
                end

                // Ignored transaction: only a fully idle bus ends it.
                BUSWAIT: begin
                    if (Frame && Irdy) begin
                        state_q <= IDLE;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef PCI_PARITY_EN
    logic par_q;

    // Parity trails its read data cycle by one clock, as on a real PCI bus.
    always_ff @(posedge Clock) begin
        if (RST) begin
            par_q <= 1'b0;
        end else if ((state_q == DATA) && adOe_q && !trdy_q) begin
            par_q <= (^adOut_q) ^ (^CBE);
        end else begin
            par_q <= 1'b0;
        end
    end

    assign Par = par_q;
`endif

    assign AD_out = adOut_q;
    assign AD_oe  = adOe_q;
    assign Devsel = devsel_q;
    assign Trdy   = trdy_q;
    assign Stop   = stop_q;

endmodule

// File: tb/tb_pci_target_burst.sv
// ---------------------------------------------------------------------------
// tb_pci_target_burst -- self-checking bench for pci_target_burst.
//
// Two instances: dut (no wait states) runs a table of per-cycle vectors;
// dutWs (WAIT_STATES=2) runs hand-written wait-state and reset sequences.
// Each vector gives the bus inputs for one clock and the outputs expected
// just after the edge that samples them.
// ---------------------------------------------------------------------------
module tb_pci_target_burst;

    logic Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Inputs and outputs of the zero-wait-state instance
    logic        rst   = 1'b0;
    logic        frame = 1'b1;
    logic        irdy  = 1'b1;
    logic [3:0]  cbe   = 4'h0;
    logic [31:0] adIn  = 32'd0;
    logic [31:0] adOut;
    logic        adOe, devsel, trdy, stop;

    // Inputs and outputs of the two-wait-state instance
    logic        rst2   = 1'b0;
    logic        frame2 = 1'b1;
    logic        irdy2  = 1'b1;
    logic [3:0]  cbe2   = 4'h0;
    logic [31:0] adIn2  = 32'd0;
    logic [31:0] adOut2;
    logic        adOe2, devsel2, trdy2, stop2;

`ifdef PCI_PARITY_EN
    logic par, par2;
`endif

    pci_target_burst #(.BASE_ADDR(32'd21), .DEPTH(8), .WAIT_STATES(0)) dut (
        .Clock(Clock), .RST(rst), .Frame(frame), .Irdy(irdy), .CBE(cbe),
        .AD_in(adIn), .AD_out(adOut), .AD_oe(adOe), .Devsel(devsel),
        .Trdy(trdy), .Stop(stop)
`ifdef PCI_PARITY_EN
        , .Par(par)
`endif
    );

    pci_target_burst #(.BASE_ADDR(32'd21), .DEPTH(8), .WAIT_STATES(2)) dutWs (
        .Clock(Clock), .RST(rst2), .Frame(frame2), .Irdy(irdy2), .CBE(cbe2),
        .AD_in(adIn2), .AD_out(adOut2), .AD_oe(adOe2), .Devsel(devsel2),
        .Trdy(trdy2), .Stop(stop2)
`ifdef PCI_PARITY_EN
        , .Par(par2)
`endif
    );

    // rfi = {rst, frame, irdy}; exp = {devsel, trdy, stop, adOe, checkData}
    typedef struct {
        string       name;
        logic [2:0]  rfi;
        logic [3:0]  cbe;
        logic [31:0] ad;
        logic [4:0]  exp;
        logic [31:0] expData;
    } vec_t;

    int checkCount = 0;
    int passCount  = 0;
    vec_t vecs[$];

    function automatic vec_t mkVec(string n, logic [2:0] rfi, logic [3:0] c,
                                   logic [31:0] a, logic [4:0] e,
                                   logic [31:0] d);
        vec_t v;
        v.name    = n;
        v.rfi     = rfi;
        v.cbe     = c;
        v.ad      = a;
        v.exp     = e;
        v.expData = d;
        return v;
    endfunction

    // Compare one value and keep the running tallies
    task automatic checkField(input string what, input logic [31:0] got,
                              input logic [31:0] expv);
        checkCount++;
        if (got === expv) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", what, got, expv);
        end
    endtask

    // Drive one clock of inputs to the selected instance, hold the other idle,
    // then wait until just after the sampling edge.
    task automatic applyStimulus(input logic sel, input vec_t v);
        @(negedge Clock);
        if (sel) begin
            {rst2, frame2, irdy2} = v.rfi;
            cbe2  = v.cbe;
            adIn2 = v.ad;
            {rst, frame, irdy} = 3'b011;
        end else begin
            {rst, frame, irdy} = v.rfi;
            cbe  = v.cbe;
            adIn = v.ad;
            {rst2, frame2, irdy2} = 3'b011;
        end
        @(posedge Clock);
        #1;
    endtask

    task automatic checkOutput(input logic sel, input vec_t v);
        logic [3:0]  gotCtl;
        logic [31:0] gotData;
        gotCtl  = sel ? {devsel2, trdy2, stop2, adOe2} : {devsel, trdy, stop, adOe};
        gotData = sel ? adOut2 : adOut;
        checkField({v.name, " Devsel"}, {31'd0, gotCtl[3]}, {31'd0, v.exp[4]});
        checkField({v.name, " Trdy"},   {31'd0, gotCtl[2]}, {31'd0, v.exp[3]});
        checkField({v.name, " Stop"},   {31'd0, gotCtl[1]}, {31'd0, v.exp[2]});
        checkField({v.name, " AD_oe"},  {31'd0, gotCtl[0]}, {31'd0, v.exp[1]});
        if (v.exp[0]) begin
            checkField({v.name, " AD_out"}, gotData, v.expData);
        end
    endtask

    task automatic step(input logic sel, input vec_t v);
        applyStimulus(sel, v);
        checkOutput(sel, v);
    endtask

    initial begin
        // ---- zero-wait-state vector table ----
        vecs.push_back(mkVec("reset",      3'b111, 4'h0, 32'd0,  5'b11101, 32'd0));
        // write burst 1,2,3 to words 21..23
        vecs.push_back(mkVec("wr addr",    3'b001, 4'h7, 32'd21, 5'b00100, 32'd0));
        vecs.push_back(mkVec("wr d0",      3'b000, 4'h0, 32'd1,  5'b00100, 32'd0));
        vecs.push_back(mkVec("wr d1",      3'b000, 4'h0, 32'd2,  5'b00100, 32'd0));
        vecs.push_back(mkVec("wr d2 last", 3'b010, 4'h0, 32'd3,  5'b11100, 32'd0));
        vecs.push_back(mkVec("wr idle",    3'b011, 4'h0, 32'd0,  5'b11100, 32'd0));
        // read burst back
        vecs.push_back(mkVec("rd addr",    3'b001, 4'h6, 32'd21, 5'b00111, 32'd1));
        vecs.push_back(mkVec("rd d0",      3'b000, 4'h0, 32'd0,  5'b00111, 32'd2));
        vecs.push_back(mkVec("rd d1",      3'b000, 4'h0, 32'd0,  5'b00111, 32'd3));
        vecs.push_back(mkVec("rd d2 last", 3'b010, 4'h0, 32'd0,  5'b11100, 32'd0));
        vecs.push_back(mkVec("rd idle",    3'b011, 4'h0, 32'd0,  5'b11100, 32'd0));
        // read burst with Irdy stalled twice in phase 2
        vecs.push_back(mkVec("st addr",    3'b001, 4'h6, 32'd21, 5'b00111, 32'd1));
        vecs.push_back(mkVec("st d0",      3'b000, 4'h0, 32'd0,  5'b00111, 32'd2));
        vecs.push_back(mkVec("st hold1",   3'b001, 4'h0, 32'd0,  5'b00111, 32'd2));
        vecs.push_back(mkVec("st hold2",   3'b001, 4'h0, 32'd0,  5'b00111, 32'd2));
        vecs.push_back(mkVec("st d1",      3'b000, 4'h0, 32'd0,  5'b00111, 32'd3));
        vecs.push_back(mkVec("st d2 last", 3'b010, 4'h0, 32'd0,  5'b11100, 32'd0));
        vecs.push_back(mkVec("st idle",    3'b011, 4'h0, 32'd0,  5'b11100, 32'd0));
        // low-half byte-enable write to word 22, then read it back
        vecs.push_back(mkVec("be addr",    3'b001, 4'h7, 32'd22, 5'b00100, 32'd0));
        vecs.push_back(mkVec("be last",    3'b010, 4'hC, 32'hAABBCCDD, 5'b11100, 32'd0));
        vecs.push_back(mkVec("be idle",    3'b011, 4'h0, 32'd0,  5'b11100, 32'd0));
        vecs.push_back(mkVec("be rd addr", 3'b001, 4'h6, 32'd22, 5'b00111, 32'h0000CCDD));
        vecs.push_back(mkVec("be rd last", 3'b010, 4'h0, 32'd0,  5'b11100, 32'd0));
        vecs.push_back(mkVec("be rd idle", 3'b011, 4'h0, 32'd0,  5'b11100, 32'd0));
        // address miss: Devsel never asserts, Frame=0 in BUSWAIT is ignored
        vecs.push_back(mkVec("miss addr",  3'b001, 4'h6, 32'd40, 5'b11100, 32'd0));
        vecs.push_back(mkVec("miss data",  3'b000, 4'h0, 32'd0,  5'b11100, 32'd0));
        vecs.push_back(mkVec("miss frup",  3'b010, 4'h0, 32'd0,  5'b11100, 32'd0));
        vecs.push_back(mkVec("miss rel",   3'b011, 4'h0, 32'd0,  5'b11100, 32'd0));
        // overrun: 10-word write from word 21 (data 101..110)
        vecs.push_back(mkVec("ov addr",    3'b001, 4'h7, 32'd21, 5'b00100, 32'd0));
        for (int k = 0; k < 7; k++) begin
            vecs.push_back(mkVec($sformatf("ov d%0d", k), 3'b000, 4'h0,
                                 32'd101 + 32'(k), 5'b00100, 32'd0));
        end
        vecs.push_back(mkVec("ov d7 disc", 3'b000, 4'h0, 32'd108, 5'b01000, 32'd0));
        vecs.push_back(mkVec("ov disc",    3'b000, 4'h0, 32'd109, 5'b01000, 32'd0));
        vecs.push_back(mkVec("ov frup",    3'b010, 4'h0, 32'd110, 5'b11100, 32'd0));
        vecs.push_back(mkVec("ov idle",    3'b011, 4'h0, 32'd0,  5'b11100, 32'd0));
        // last word holds the 8th datum, first word was not overwritten
        vecs.push_back(mkVec("r28 addr",   3'b001, 4'h6, 32'd28, 5'b00111, 32'd108));
        vecs.push_back(mkVec("r28 last",   3'b010, 4'h0, 32'd0,  5'b11100, 32'd0));
        vecs.push_back(mkVec("r28 idle",   3'b011, 4'h0, 32'd0,  5'b11100, 32'd0));
        vecs.push_back(mkVec("r21 addr",   3'b001, 4'h6, 32'd21, 5'b00111, 32'd101));
        vecs.push_back(mkVec("r21 last",   3'b010, 4'h0, 32'd0,  5'b11100, 32'd0));
        vecs.push_back(mkVec("r21 idle",   3'b011, 4'h0, 32'd0,  5'b11100, 32'd0));
        // range edges and a non-memory command
        vecs.push_back(mkVec("m29 addr",   3'b001, 4'h6, 32'd29, 5'b11100, 32'd0));
        vecs.push_back(mkVec("m29 rel",    3'b011, 4'h0, 32'd0,  5'b11100, 32'd0));
        vecs.push_back(mkVec("m20 addr",   3'b001, 4'h7, 32'd20, 5'b11100, 32'd0));
        vecs.push_back(mkVec("m20 rel",    3'b011, 4'h0, 32'd0,  5'b11100, 32'd0));
        vecs.push_back(mkVec("io addr",    3'b001, 4'h2, 32'd21, 5'b11100, 32'd0));
        vecs.push_back(mkVec("io rel",     3'b011, 4'h0, 32'd0,  5'b11100, 32'd0));

        foreach (vecs[i]) begin
            step(1'b0, vecs[i]);
        end

        // ---- two-wait-state sequences: write, read, reset mid-burst ----
        step(1'b1, mkVec("ws reset",      3'b111, 4'h0, 32'd0,    5'b11101, 32'd0));
        step(1'b1, mkVec("ws wr addr",    3'b001, 4'h7, 32'd21,   5'b01100, 32'd0));
        step(1'b1, mkVec("ws wr wait1",   3'b000, 4'h0, 32'h55,   5'b01100, 32'd0));
        step(1'b1, mkVec("ws wr wait2",   3'b000, 4'h0, 32'h55,   5'b00100, 32'd0));
        step(1'b1, mkVec("ws wr xfer0",   3'b000, 4'h0, 32'h55,   5'b01100, 32'd0));
        step(1'b1, mkVec("ws wr wait3",   3'b000, 4'h0, 32'h66,   5'b01100, 32'd0));
        step(1'b1, mkVec("ws wr wait4",   3'b000, 4'h0, 32'h66,   5'b00100, 32'd0));
        step(1'b1, mkVec("ws wr last",    3'b010, 4'h0, 32'h66,   5'b11100, 32'd0));
        step(1'b1, mkVec("ws wr idle",    3'b011, 4'h0, 32'd0,    5'b11100, 32'd0));
        step(1'b1, mkVec("ws rd addr",    3'b001, 4'h6, 32'd21,   5'b01110, 32'd0));
        step(1'b1, mkVec("ws rd wait",    3'b000, 4'h0, 32'd0,    5'b01110, 32'd0));
        step(1'b1, mkVec("ws rd data0",   3'b000, 4'h0, 32'd0,    5'b00111, 32'h55));
        step(1'b1, mkVec("ws rd xfer0",   3'b000, 4'h0, 32'd0,    5'b01110, 32'd0));
        step(1'b1, mkVec("ws reset mid",  3'b100, 4'h0, 32'd0,    5'b11101, 32'd0));
        step(1'b1, mkVec("ws post reset", 3'b011, 4'h0, 32'd0,    5'b11101, 32'd0));
        step(1'b1, mkVec("ws rd22 addr",  3'b001, 4'h6, 32'd22,   5'b01110, 32'd0));
        step(1'b1, mkVec("ws rd22 wait",  3'b000, 4'h0, 32'd0,    5'b01110, 32'd0));
        step(1'b1, mkVec("ws rd22 data",  3'b000, 4'h0, 32'd0,    5'b00111, 32'h66));
        step(1'b1, mkVec("ws rd22 last",  3'b010, 4'h0, 32'd0,    5'b11100, 32'd0));
        step(1'b1, mkVec("ws idle",       3'b011, 4'h0, 32'd0,    5'b11100, 32'd0));

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
